// File: rtl/ball_physics_engine.sv
// Vertical ball-motion engine: fixed-point position/velocity integration
// under gravity, with floor/ceiling restitution, a paddle that drives a
// rising ball back down, and rest detection at the floor that ends the game.
module ball_physics_engine #(
  parameter int Y_W      = 9,
  parameter int MAX_Y    = 309,
  parameter int MIN_Y    = 5,
  parameter int FRAC     = 4,
  parameter int V_W      = 12,
  parameter int GRAV     = 2,
  parameter int V_REST   = 8,
  parameter int TICK_DIV = 219089
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           launch,
  input  logic [Y_W-1:0] home,
  input  logic [1:0]     k,
  input  logic [Y_W-1:0] paddle_y,
  input  logic [7:0]     paddle_v,
  output logic [Y_W-1:0] pos_y,
  output logic [V_W-1:0] vel,
  output logic [1:0]     state,
  output logic           bounce_pulse,
  output logic           rest_pulse,
  output logic           over_flag
);

  // Stored position width, signed working width for the position step,
  // and the width used for the restitution product.
  localparam int P_W   = Y_W + FRAC;
  localparam int S_W   = Y_W + FRAC + 2;
  localparam int M_W   = V_W + 3;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic signed [S_W-1:0] FLOOR_P = S_W'(MAX_Y << FRAC);
  localparam logic signed [S_W-1:0] CEIL_P  = S_W'(MIN_Y << FRAC);
  localparam logic signed [V_W:0]   GRAV_E  = (V_W+1)'(GRAV);
  localparam logic signed [V_W:0]   V_MAX   = (V_W+1)'((1 << (V_W-1)) - 1);
  localparam logic [M_W-1:0]        REST_M  = M_W'(V_REST);
  localparam logic [CNT_W-1:0]      CNT_END = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FALL = 2'b01,
    ST_RISE = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  logic [CNT_W-1:0]      cnt_r;
  logic                  tick_s;

  state_t                state_r, state_nxt;
  logic [P_W-1:0]        pos_r, pos_nxt;
  logic signed [V_W-1:0] vel_r, vel_nxt;
  logic                  over_r, over_nxt;
  logic                  bounce_r, bounce_nxt;
  logic                  rest_r, rest_nxt;

  logic [Y_W-1:0]        home_cl_s;
  logic signed [S_W-1:0] pos_ext_s;
  logic signed [S_W-1:0] vel_ext_s;
  logic signed [S_W-1:0] p_next_s;
  logic signed [S_W-1:0] paddle_p_s;
  logic signed [V_W:0]   v_sum_s;
  logic signed [V_W-1:0] v_next_s;
  logic [M_W-1:0]        vel_sx_s;
  logic [M_W-1:0]        vel_mag_s;
  logic [2:0]            k_fact_s;
  logic [M_W-1:0]        prod_s;
  logic [M_W-1:0]        r_s;
  logic [V_W-1:0]        r_v_s;
  logic [V_W-1:0]        paddle_vel_s;
  logic                  vel_pos_s, vel_neg_s;
  logic                  hit_floor_s, hit_paddle_s, hit_ceil_s, rest_s;

  // Physics tick divider; launch restarts the tick phase.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick_s = (cnt_r == CNT_END);

  // Serve position: home row clamped into the playfield.
  always_comb begin
    if (home < Y_W'(MIN_Y)) begin
      home_cl_s = Y_W'(MIN_Y);
    end else if (home > Y_W'(MAX_Y)) begin
      home_cl_s = Y_W'(MAX_Y);
    end else begin
      home_cl_s = home;
    end
  end

  // Candidate next position/velocity and the boundary hit tests.
  always_comb begin
    pos_ext_s    = $signed({2'b00, pos_r});
    vel_ext_s    = {{(S_W-V_W){vel_r[V_W-1]}}, vel_r};
    p_next_s     = pos_ext_s + vel_ext_s;
    v_sum_s      = $signed({vel_r[V_W-1], vel_r}) + GRAV_E;
    if (v_sum_s > V_MAX) begin
      v_next_s = V_MAX[V_W-1:0];
    end else begin
      v_next_s = v_sum_s[V_W-1:0];
    end
    // Restitution uses the speed magnitude, so one product serves floor and ceiling.
    vel_sx_s     = {{(M_W-V_W){vel_r[V_W-1]}}, vel_r};
    if (vel_r[V_W-1]) begin
      vel_mag_s = {M_W{1'b0}} - vel_sx_s;
    end else begin
      vel_mag_s = vel_sx_s;
    end
    k_fact_s     = {1'b0, k} + 3'd4;
    prod_s       = vel_mag_s * {{(M_W-3){1'b0}}, k_fact_s};
    r_s          = prod_s >> 3'd3;
    r_v_s        = r_s[V_W-1:0];
    rest_s       = (r_s < REST_M);
    paddle_p_s   = $signed({2'b00, paddle_y, {FRAC{1'b0}}});
    paddle_vel_s = V_W'({paddle_v, {(FRAC-1){1'b0}}});
    vel_neg_s    = vel_r[V_W-1];
    vel_pos_s    = !vel_r[V_W-1] && (vel_r != {V_W{1'b0}});
    hit_floor_s  = vel_pos_s && (p_next_s >= FLOOR_P);
    hit_paddle_s = (paddle_y != {Y_W{1'b0}}) && vel_neg_s &&
                   (pos_ext_s >= paddle_p_s) && (p_next_s < paddle_p_s);
    hit_ceil_s   = vel_neg_s && (p_next_s <= CEIL_P);
  end

  // Next-state logic: launch, then per-tick motion in FALL/RISE; otherwise hold.
  always_comb begin
    state_nxt  = state_r;
    pos_nxt    = pos_r;
    vel_nxt    = vel_r;
    over_nxt   = over_r;
    bounce_nxt = 1'b0;
    rest_nxt   = 1'b0;
    if (launch) begin
      pos_nxt   = {home_cl_s, {FRAC{1'b0}}};
      vel_nxt   = {V_W{1'b0}};
      state_nxt = ST_FALL;
      over_nxt  = 1'b0;
    end else if (tick_s) begin
      case (state_r)
        ST_FALL, ST_RISE: begin
          if (hit_floor_s) begin
            pos_nxt = FLOOR_P[P_W-1:0];
            if (rest_s) begin
              vel_nxt   = {V_W{1'b0}};
              state_nxt = ST_OVER;
              over_nxt  = 1'b1;
              rest_nxt  = 1'b1;
            end else begin
              vel_nxt    = {V_W{1'b0}} - r_v_s;
              state_nxt  = ST_RISE;
              bounce_nxt = 1'b1;
            end
          end else if (hit_paddle_s) begin
            pos_nxt   = paddle_p_s[P_W-1:0];
            vel_nxt   = paddle_vel_s;
            state_nxt = ST_FALL;
          end else if (hit_ceil_s) begin
            pos_nxt    = CEIL_P[P_W-1:0];
            vel_nxt    = r_v_s;
            state_nxt  = ST_FALL;
            bounce_nxt = 1'b1;
          end else begin
            pos_nxt   = p_next_s[P_W-1:0];
            vel_nxt   = v_next_s;
            state_nxt = v_next_s[V_W-1] ? ST_RISE : ST_FALL;
          end
        end
        default: begin
          state_nxt = state_r;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Game state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pos_r    <= {P_W{1'b0}};
      vel_r    <= {V_W{1'b0}};
      over_r   <= 1'b0;
      bounce_r <= 1'b0;
      rest_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      pos_r    <= pos_nxt;
      vel_r    <= vel_nxt;
      over_r   <= over_nxt;
      bounce_r <= bounce_nxt;
      rest_r   <= rest_nxt;
    end
  end

  assign pos_y        = pos_r[P_W-1:FRAC];
  assign vel          = vel_r;
  assign state        = state_r;
  assign bounce_pulse = bounce_r;
  assign rest_pulse   = rest_r;
  assign over_flag    = over_r;

endmodule

// File: tb/tb_ball_physics_engine.sv
// Directed bench for ball_physics_engine: hand-computed trajectories with
// one tick per clock, plus a second instance with a 3-clock tick divider.
module tb_ball_physics_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch;
  logic [8:0]  home;
  logic [1:0]  k;
  logic [8:0]  paddle_y;
  logic [7:0]  paddle_v;
  logic [8:0]  pos_y;
  logic [11:0] vel;
  logic [1:0]  state;
  logic        bounce_pulse, rest_pulse, over_flag;
  logic [8:0]  pos_y2;
  logic [11:0] vel2;
  logic [1:0]  state2;
  logic        bounce2, rest2, over2;

  int n_cmp  = 0;
  int n_fail = 0;

  ball_physics_engine #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .launch(launch), .home(home), .k(k),
    .paddle_y(paddle_y), .paddle_v(paddle_v), .pos_y(pos_y), .vel(vel),
    .state(state), .bounce_pulse(bounce_pulse), .rest_pulse(rest_pulse),
    .over_flag(over_flag)
  );

  ball_physics_engine #(.TICK_DIV(3)) dut2 (
    .clk(clk), .rst(rst), .launch(launch), .home(home), .k(k),
    .paddle_y(paddle_y), .paddle_v(paddle_v), .pos_y(pos_y2), .vel(vel2),
    .state(state2), .bounce_pulse(bounce2), .rest_pulse(rest2),
    .over_flag(over2)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_launch(input int h);
    home = 9'(h);
    launch = 1'b1;
    step(1);
    launch = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(20);
    n_cmp++; if (pos_y !== 9'd0) begin n_fail++; $display("FAIL reset_pos got %0d want 0", pos_y); end
    n_cmp++; if (vel !== 12'd0) begin n_fail++; $display("FAIL reset_vel got %0d want 0", vel); end
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if ({bounce_pulse, rest_pulse, over_flag} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bounce_pulse, rest_pulse, over_flag}); end
    n_cmp++; if (state2 !== 2'b00) begin n_fail++; $display("FAIL reset_state2 got %0d want 0", state2); end
  endtask

  task automatic test_fall;
    do_launch(100);
    n_cmp++; if (pos_y !== 9'd100) begin n_fail++; $display("FAIL launch_pos got %0d want 100", pos_y); end
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL launch_state got %0d want 1", state); end
    step(8);
    n_cmp++; if (pos_y !== 9'd103) begin n_fail++; $display("FAIL fall_pos got %0d want 103", pos_y); end
    n_cmp++; if ($signed(vel) !== 16) begin n_fail++; $display("FAIL fall_vel got %0d want 16", $signed(vel)); end
  endtask

  task automatic test_tick_div;
    do_launch(100);
    step(2);
    n_cmp++; if (vel2 !== 12'd0) begin n_fail++; $display("FAIL div_vel_early got %0d want 0", vel2); end
    n_cmp++; if ($signed(vel) !== 4) begin n_fail++; $display("FAIL div_ref_vel got %0d want 4", $signed(vel)); end
    step(1);
    n_cmp++; if (vel2 !== 12'd2) begin n_fail++; $display("FAIL div_vel_tick got %0d want 2", vel2); end
  endtask

  task automatic test_floor_bounce;
    k = 2'd3;
    do_launch(208);
    step(41);
    n_cmp++; if (pos_y !== 9'd309) begin n_fail++; $display("FAIL floor_pos got %0d want 309", pos_y); end
    n_cmp++; if ($signed(vel) !== -70) begin n_fail++; $display("FAIL floor_vel got %0d want -70", $signed(vel)); end
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL floor_state got %0d want 2", state); end
    n_cmp++; if ({bounce_pulse, rest_pulse} !== 2'b10) begin n_fail++; $display("FAIL floor_pulse got %b want 10", {bounce_pulse, rest_pulse}); end
    step(1);
    n_cmp++; if (bounce_pulse !== 1'b0) begin n_fail++; $display("FAIL floor_pulse_width got %b want 0", bounce_pulse); end
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL rising_state got %0d want 2", state); end
  endtask

  task automatic test_launch_clamp_high;
    do_launch(400);
    n_cmp++; if (pos_y !== 9'd309) begin n_fail++; $display("FAIL clamp_hi_pos got %0d want 309", pos_y); end
    n_cmp++; if (vel !== 12'd0) begin n_fail++; $display("FAIL clamp_hi_vel got %0d want 0", vel); end
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL clamp_hi_state got %0d want 1", state); end
    n_cmp++; if (over_flag !== 1'b0) begin n_fail++; $display("FAIL clamp_hi_over got %b want 0", over_flag); end
  endtask

  task automatic test_rest;
    k = 2'd0;
    do_launch(307);
    step(7);
    n_cmp++; if (state !== 2'b11) begin n_fail++; $display("FAIL rest_state got %0d want 3", state); end
    n_cmp++; if ({bounce_pulse, rest_pulse, over_flag} !== 3'b011) begin n_fail++; $display("FAIL rest_flags got %b want 011", {bounce_pulse, rest_pulse, over_flag}); end
    n_cmp++; if (pos_y !== 9'd309) begin n_fail++; $display("FAIL rest_pos got %0d want 309", pos_y); end
    n_cmp++; if (vel !== 12'd0) begin n_fail++; $display("FAIL rest_vel got %0d want 0", vel); end
    step(5);
    n_cmp++; if ({state, pos_y} !== {2'b11, 9'd309}) begin n_fail++; $display("FAIL over_hold got %0d/%0d want 3/309", state, pos_y); end
    n_cmp++; if ({rest_pulse, over_flag} !== 2'b01) begin n_fail++; $display("FAIL over_flags got %b want 01", {rest_pulse, over_flag}); end
  endtask

  task automatic test_launch_clamp_low;
    do_launch(2);
    n_cmp++; if (pos_y !== 9'd5) begin n_fail++; $display("FAIL clamp_lo_pos got %0d want 5", pos_y); end
    n_cmp++; if ({state, over_flag} !== 3'b010) begin n_fail++; $display("FAIL clamp_lo_state got %b want 010", {state, over_flag}); end
  endtask

  task automatic test_paddle;
    k = 2'd3;
    paddle_y = 9'd200;
    paddle_v = 8'd6;
    do_launch(132);
    step(54);
    n_cmp++; if ($signed(vel) !== -92) begin n_fail++; $display("FAIL pad_bounce_vel got %0d want -92", $signed(vel)); end
    step(27);
    n_cmp++; if (pos_y !== 9'd200) begin n_fail++; $display("FAIL pad_pos got %0d want 200", pos_y); end
    n_cmp++; if ($signed(vel) !== 48) begin n_fail++; $display("FAIL pad_vel got %0d want 48", $signed(vel)); end
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL pad_state got %0d want 1", state); end
    n_cmp++; if ({bounce_pulse, rest_pulse} !== 2'b00) begin n_fail++; $display("FAIL pad_pulse got %b want 00", {bounce_pulse, rest_pulse}); end
  endtask

  task automatic test_ceiling;
    k = 2'd3;
    paddle_y = 9'd200;
    paddle_v = 8'd255;
    do_launch(132);
    step(81);
    n_cmp++; if ($signed(vel) !== 2040) begin n_fail++; $display("FAIL strike_vel got %0d want 2040", $signed(vel)); end
    paddle_y = 9'd0;
    step(1);
    n_cmp++; if ($signed(vel) !== -1785) begin n_fail++; $display("FAIL fast_floor_vel got %0d want -1785", $signed(vel)); end
    step(2);
    n_cmp++; if ({pos_y, bounce_pulse} !== {9'd86, 1'b0}) begin n_fail++; $display("FAIL pre_ceil got %0d/%b want 86/0", pos_y, bounce_pulse); end
    step(1);
    n_cmp++; if (pos_y !== 9'd5) begin n_fail++; $display("FAIL ceil_pos got %0d want 5", pos_y); end
    n_cmp++; if ($signed(vel) !== 1558) begin n_fail++; $display("FAIL ceil_vel got %0d want 1558", $signed(vel)); end
    n_cmp++; if ({state, bounce_pulse} !== 3'b011) begin n_fail++; $display("FAIL ceil_state got %b want 011", {state, bounce_pulse}); end
  endtask

  task automatic test_reset_mid;
    do_launch(100);
    step(5);
    rst = 1'b1;
    step(1);
    n_cmp++; if ({pos_y, vel, state} !== 23'd0) begin n_fail++; $display("FAIL rst_mid got %0d/%0d/%0d want 0/0/0", pos_y, vel, state); end
    n_cmp++; if ({bounce_pulse, rest_pulse, over_flag} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags got %b want 000", {bounce_pulse, rest_pulse, over_flag}); end
    rst = 1'b0;
    step(3);
    n_cmp++; if ({pos_y, state} !== 11'd0) begin n_fail++; $display("FAIL idle_hold got %0d/%0d want 0/0", pos_y, state); end
  endtask

  initial begin
    rst = 1'b1;
    launch = 1'b0;
    home = 9'd0;
    k = 2'd0;
    paddle_y = 9'd0;
    paddle_v = 8'd0;
    test_reset();
    test_fall();
    test_tick_div();
    test_floor_bounce();
    test_launch_clamp_high();
    test_rest();
    test_launch_clamp_low();
    test_paddle();
    test_ceiling();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
